// File: rtl/redun_mont_pkg.sv
// redun_mont_pkg: shared redundant-form sizes, types and conversions for the Montgomery datapath
package redun_mont_pkg;
  localparam int WRD_BITS = 16;
  localparam int NUM_WRDS = 65;
  localparam int DAT_BITS = WRD_BITS * NUM_WRDS;
  localparam int RESOLVE_WRDS_PER_CYC = 5;
  typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;
  typedef logic [DAT_BITS-1:0] fe_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} resolve_state_t;
  function automatic fe_t from_redun(redun0_t r);
    fe_t f;
    f = '0;
    for (int i = 0; i < NUM_WRDS; i++) f = f + (fe_t'(r[i]) << (WRD_BITS * i));
    return f;
  endfunction
  function automatic redun0_t to_redun(fe_t f);
    redun0_t r;
    for (int i = 0; i < NUM_WRDS; i++) r[i] = {1'b0, f[i*WRD_BITS +: WRD_BITS]};
    return r;
  endfunction
endpackage

// File: rtl/redun_carry_chunk.sv
// redun_carry_chunk: combinational carry ripple across N redundant words
// wrds: N words of WRD_BITS+1 bits, word 0 lowest; cin/cout: 2-bit carry; sum: N*WRD_BITS resolved bits
module redun_carry_chunk
  import redun_mont_pkg::*;
#(
  parameter int N = RESOLVE_WRDS_PER_CYC
) (
  input  logic [N*(WRD_BITS+1)-1:0] wrds,
  input  logic [1:0]                cin,
  output logic [N*WRD_BITS-1:0]     sum,
  output logic [1:0]                cout
);
  logic [1:0] c;
  logic [WRD_BITS+1:0] s;
  always_comb begin
    c = cin;
    s = '0;
    sum = '0;
    for (int j = 0; j < N; j++) begin
      s = {1'b0, wrds[j*(WRD_BITS+1) +: WRD_BITS+1]} + {{WRD_BITS{1'b0}}, c};
      sum[j*WRD_BITS +: WRD_BITS] = s[WRD_BITS-1:0];
      c = s[WRD_BITS+1:WRD_BITS];
    end
    cout = c;
  end
endmodule

// File: rtl/redun_carry_resolve.sv
// redun_carry_resolve: sequential redundant-to-binary converter, WRDS_PER_CYC words per clock
// i_dat/i_val/o_rdy: redundant input handshake; o_dat/o_ovf/o_val/i_rdy: resolved output handshake
// o_ovf flags a sum >= 2^DAT_BITS; o_dat then holds the sum mod 2^DAT_BITS
module redun_carry_resolve
  import redun_mont_pkg::*;
#(
  parameter int WRDS_PER_CYC = RESOLVE_WRDS_PER_CYC
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  redun0_t i_dat,
  input  logic    i_val,
  output logic    o_rdy,
  output fe_t     o_dat,
  output logic    o_ovf,
  output logic    o_val,
  input  logic    i_rdy
);
  localparam int NUM_CYC = NUM_WRDS / WRDS_PER_CYC;
  localparam int IW = $clog2(NUM_CYC + 1);
  localparam int CHUNK = WRDS_PER_CYC * (WRD_BITS + 1);
  localparam int OCHUNK = WRDS_PER_CYC * WRD_BITS;
  if (NUM_WRDS % WRDS_PER_CYC != 0) begin : g_bad
    $fatal(1, "WRDS_PER_CYC must divide NUM_WRDS");
  end
  resolve_state_t state;
  logic [NUM_WRDS*(WRD_BITS+1)-1:0] in_reg;
  logic [IW-1:0] idx;
  logic [1:0] carry, cout;
  logic [OCHUNK-1:0] sum;
  redun_carry_chunk #(.N(WRDS_PER_CYC)) u_chunk (
    .wrds(in_reg[idx*CHUNK +: CHUNK]),
    .cin (carry),
    .sum (sum),
    .cout(cout)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      o_rdy <= 1'b1;
      o_val <= 1'b0;
      o_dat <= '0;
      o_ovf <= 1'b0;
      carry <= '0;
      idx <= '0;
      in_reg <= '0;
    end else
      case (state)
        IDLE: if (i_val) begin
          in_reg <= i_dat;
          carry <= '0;
          idx <= '0;
          o_rdy <= 1'b0;
          state <= BUSY;
        end
        BUSY: begin
          o_dat[idx*OCHUNK +: OCHUNK] <= sum;
          carry <= cout;
          idx <= idx + 1'b1;
          if (idx == IW'(NUM_CYC - 1)) begin
            o_ovf <= cout != 2'd0;
            o_val <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (i_rdy) begin
          o_val <= 1'b0;
          o_rdy <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_redun_carry_resolve.sv
// tb_redun_carry_resolve: randomized self-checking bench against an exact-sum reference model
module tb_redun_carry_resolve;
  import redun_mont_pkg::*;
  localparam int NUM_CYC = NUM_WRDS / RESOLVE_WRDS_PER_CYC;
  typedef logic [DAT_BITS+1:0] wide_t;
  logic i_clk = 1'b0;
  logic i_rst, i_val, i_rdy, o_rdy, o_ovf, o_val;
  redun0_t i_dat;
  fe_t o_dat;
  int total = 0, bad = 0;
  always #5 i_clk = ~i_clk;
  redun_carry_resolve dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_dat(i_dat),
    .i_val(i_val),
    .o_rdy(o_rdy),
    .o_dat(o_dat),
    .o_ovf(o_ovf),
    .o_val(o_val),
    .i_rdy(i_rdy)
  );
  task automatic check(input string tag, input logic [DAT_BITS:0] got, input logic [DAT_BITS:0] exp);
    logic [DAT_BITS:0] g, e;
    int lo;
    total++;
    if (got !== exp) begin
      bad++;
      lo = 0;
      for (int i = DAT_BITS; i >= 0; i--) if (got[i] !== exp[i]) lo = i;
      g = got >> lo;
      e = exp >> lo;
      $display("FAIL %s from bit %0d: got=%h exp=%h", tag, lo, g[63:0], e[63:0]);
    end
  endtask
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  function automatic wide_t model(input redun0_t d);
    wide_t s;
    s = '0;
    for (int i = 0; i < NUM_WRDS; i++) s = s + (wide_t'(d[i]) << (WRD_BITS * i));
    return s;
  endfunction
  function automatic redun0_t rnd_dat();
    redun0_t d;
    int m;
    m = $urandom_range(0, 3);
    for (int i = 0; i < NUM_WRDS; i++)
      d[i] = m == 0 ? 17'h1FFFF : m == 1 ? 17'($urandom) :
             m == 2 ? ($urandom_range(0, 1) ? 17'h1FFFF : 17'h0FFFF) : 17'($urandom_range(0, 3));
    return d;
  endfunction
  // hold < 0 picks a random DONE stall; i_val is pulsed randomly while the DUT is busy or stalled
  task automatic xfer(input redun0_t d, input int hold);
    wide_t exp;
    int n, h;
    exp = model(d);
    repeat ($urandom_range(0, 2)) begin
      i_val = 1'b0;
      tick;
      check("rdy_idle", o_rdy, 1);
    end
    i_dat = d;
    i_val = 1'b1;
    tick;
    check("rdy_busy", o_rdy, 0);
    n = 0;
    while (!o_val && n < 40) begin
      i_val = 1'($urandom_range(0, 1));
      i_dat = rnd_dat();
      tick;
      n++;
      if (!o_val) check("rdy_busy", o_rdy, 0);
    end
    check("latency", n, NUM_CYC);
    h = hold < 0 ? $urandom_range(0, 4) : hold;
    for (int k = 0; k <= h; k++) begin
      check("dat", o_dat, exp[DAT_BITS-1:0]);
      check("ovf", o_ovf, exp[DAT_BITS+1:DAT_BITS] != 0);
      check("val_done", o_val, 1);
      check("rdy_done", o_rdy, 0);
      if (k < h) begin
        i_val = 1'($urandom_range(0, 1));
        i_dat = rnd_dat();
        tick;
      end
    end
    i_val = 1'b0;
    i_rdy = 1'b1;
    tick;
    i_rdy = 1'b0;
    check("val_after", o_val, 0);
    check("rdy_after", o_rdy, 1);
  endtask
  initial begin
    redun0_t d;
    int seen;
    i_rst = 1'b1;
    i_val = 1'b0;
    i_rdy = 1'b0;
    i_dat = '0;
    #12;
    check("rst_rdy", o_rdy, 1);
    check("rst_val", o_val, 0);
    check("rst_dat", o_dat, 0);
    check("rst_ovf", o_ovf, 0);
    tick;
    i_rst = 1'b0;
    tick;
    xfer('0, 0);
    for (int i = 0; i < NUM_WRDS; i++) d[i] = i == 0 ? 17'h1FFFF : 17'h0FFFF;
    xfer(d, 0);
    d = '0;
    d[NUM_WRDS-1] = 17'h10000;
    xfer(d, 0);
    d = '0;
    d[0] = 17'h10000;
    xfer(d, 0);
    d = '1;
    xfer(d, 1);
    xfer(rnd_dat(), 20);
    d = rnd_dat();
    i_dat = d;
    i_val = 1'b1;
    tick;
    i_val = 1'b0;
    repeat (6) tick;
    i_rst = 1'b1;
    #1;
    check("arst_rdy", o_rdy, 1);
    check("arst_val", o_val, 0);
    check("arst_dat", o_dat, 0);
    check("arst_ovf", o_ovf, 0);
    tick;
    i_rst = 1'b0;
    seen = 0;
    repeat (20) begin
      tick;
      seen = seen | int'(o_val);
    end
    check("arst_noval", seen, 0);
    d = '0;
    d[0] = 17'd1;
    xfer(d, 0);
    check("one_dat", o_dat, 1);
    for (int r = 0; r < 1000; r++) begin
      i_rdy = 1'b0;
      xfer(rnd_dat(), -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
